// File: rtl/pwm_gen_phased.sv
// Multi-channel PWM generator sharing one period counter. Each channel has shadowed duty,
// alignment mode and phase, reloaded glitch-free at the period boundary.
module pwm_gen_phased #(
  parameter int PWM_CNT       = 64,
  parameter int PWM_CNT_WIDTH = 24
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             cnt_enable_i,
  input  logic [PWM_CNT_WIDTH-1:0]         period_i,
  input  logic                             update_i,
  input  logic [PWM_CNT*PWM_CNT_WIDTH-1:0] active_i,
  input  logic [PWM_CNT-1:0]               center_i,
  input  logic [PWM_CNT*PWM_CNT_WIDTH-1:0] man_phase_i,
  input  logic [PWM_CNT*PWM_CNT_WIDTH-1:0] auto_phase_i,
  input  logic [PWM_CNT-1:0]               auto_end_i,
  input  logic [PWM_CNT-1:0]               ctrl_i,
  input  logic [PWM_CNT-1:0]               enable_i,
  output logic [PWM_CNT-1:0]               pwm_o,
  output logic [PWM_CNT*PWM_CNT_WIDTH-1:0] phase_o,
  output logic [PWM_CNT_WIDTH-1:0]         cnt_o,
  output logic                             period_start_o,
  output logic                             update_pending_o
);

  localparam int W = PWM_CNT_WIDTH;
  localparam logic [W-1:0] ZERO_W  = {W{1'b0}};
  localparam logic [W-1:0] ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   ZERO_W1 = {(W+1){1'b0}};

  logic [W-1:0]         cnt_r;
  logic [W-1:0]         period_sh_r;
  logic                 update_pending_r;
  logic                 period_start_r;
  logic                 valid_r;
  logic [PWM_CNT-1:0]   pwm_r;
  logic [PWM_CNT-1:0]   hit_s;
  logic [PWM_CNT*W-1:0] phase_sh_s;
  logic                 run_s;
  logic                 wrap_s;
  logic                 load_s;

  // Run, wrap and shadow-load decisions for the current cycle
  always_comb begin
    run_s  = 1'b0;
    wrap_s = 1'b0;
    load_s = 1'b0;
    if (cnt_enable_i && (period_sh_r != ZERO_W)) begin
      run_s  = 1'b1;
      wrap_s = (cnt_r == (period_sh_r - ONE_W));
    end else begin
      run_s  = 1'b0;
      wrap_s = 1'b0;
    end
    // A stopped counter never wraps, so a pending request is applied straight away.
    if (wrap_s) begin
      load_s = update_pending_r || update_i;
    end else begin
      load_s = !run_s && update_pending_r;
    end
  end

  // Main counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= ZERO_W;
    end else if (!run_s || wrap_s) begin
      cnt_r <= ZERO_W;
    end else begin
      cnt_r <= cnt_r + ONE_W;
    end
  end

  // Period shadow, pending flag, period-start pulse and pipeline valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_sh_r      <= ZERO_W;
      update_pending_r <= 1'b0;
      period_start_r   <= 1'b0;
      valid_r          <= 1'b0;
    end else begin
      period_start_r <= wrap_s;
      valid_r        <= run_s;
      if (load_s) begin
        period_sh_r      <= period_i;
        update_pending_r <= 1'b0;
      end else begin
        update_pending_r <= update_pending_r | update_i;
      end
    end
  end

  for (genvar g = 0; g < PWM_CNT; g++) begin : g_ch
    logic [W-1:0] auto_lat_r;
    logic [W-1:0] active_sh_r;
    logic [W-1:0] phase_sh_r;
    logic         center_sh_r;
    logic [W:0]   per_s, ph_s, a_s, lc_s, lo_s;
    logic [W:0]   lc_r, a_r, lo_r;

    // Auto-phase latch and per-channel shadows; the load sees the latch value from before this edge
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        auto_lat_r  <= ZERO_W;
        active_sh_r <= ZERO_W;
        phase_sh_r  <= ZERO_W;
        center_sh_r <= 1'b0;
      end else begin
        if (auto_end_i[g]) begin
          auto_lat_r <= auto_phase_i[g*W +: W];
        end
        if (load_s) begin
          active_sh_r <= active_i[g*W +: W];
          center_sh_r <= center_i[g];
          phase_sh_r  <= ctrl_i[g] ? auto_lat_r : man_phase_i[g*W +: W];
        end
      end
    end

    // Phase-shifted local count and high window; edge mode is a window starting at 0
    always_comb begin
      per_s = {1'b0, period_sh_r};
      ph_s  = ({1'b0, phase_sh_r} >= per_s) ? ZERO_W1 : {1'b0, phase_sh_r};
      a_s   = ({1'b0, active_sh_r} > per_s) ? per_s : {1'b0, active_sh_r};
      if ({1'b0, cnt_r} >= ph_s) begin
        lc_s = {1'b0, cnt_r} - ph_s;
      end else begin
        lc_s = {1'b0, cnt_r} + per_s - ph_s;
      end
      if (center_sh_r) begin
        lo_s = {1'b0, (per_s[W:1] - a_s[W:1]) - {{(W-1){1'b0}}, (a_s[0] & ~per_s[0])}};
      end else begin
        lo_s = ZERO_W1;
      end
    end

    // Pipeline stage 1
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        lc_r <= ZERO_W1;
        a_r  <= ZERO_W1;
        lo_r <= ZERO_W1;
      end else begin
        lc_r <= lc_s;
        a_r  <= a_s;
        lo_r <= lo_s;
      end
    end

    assign hit_s[g]              = (lc_r >= lo_r) && (lc_r < (lo_r + a_r));
    assign phase_sh_s[g*W +: W]  = phase_sh_r;
  end

  // Pipeline stage 2: channel enable applies here only
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_r <= {PWM_CNT{1'b0}};
    end else if (valid_r) begin
      pwm_r <= hit_s & enable_i;
    end else begin
      pwm_r <= {PWM_CNT{1'b0}};
    end
  end

  assign pwm_o            = pwm_r;
  assign phase_o          = phase_sh_s;
  assign cnt_o            = cnt_r;
  assign period_start_o   = period_start_r;
  assign update_pending_o = update_pending_r;

endmodule

// File: tb/tb_pwm_gen_phased.sv
// Randomized and directed bench for pwm_gen_phased, checked against a modulo-arithmetic
// reference model of the counter, shadow reload and phased PWM waveform.
module tb_pwm_gen_phased;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_i;
  logic           cnt_enable_i;
  logic [W-1:0]   period_i;
  logic           update_i;
  logic [N*W-1:0] active_i;
  logic [N-1:0]   center_i;
  logic [N*W-1:0] man_phase_i;
  logic [N*W-1:0] auto_phase_i;
  logic [N-1:0]   auto_end_i;
  logic [N-1:0]   ctrl_i;
  logic [N-1:0]   enable_i;
  logic [N-1:0]   pwm_o;
  logic [N*W-1:0] phase_o;
  logic [W-1:0]   cnt_o;
  logic           period_start_o;
  logic           update_pending_o;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int       m_cnt, m_per;
  int       m_act[N], m_ph[N], m_lat[N];
  bit       m_cen[N];
  bit       m_pend, m_pstart;
  logic [N-1:0] m_pwm, m_ideal;

  pwm_gen_phased #(.PWM_CNT(N), .PWM_CNT_WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .cnt_enable_i(cnt_enable_i), .period_i(period_i),
    .update_i(update_i), .active_i(active_i), .center_i(center_i),
    .man_phase_i(man_phase_i), .auto_phase_i(auto_phase_i), .auto_end_i(auto_end_i),
    .ctrl_i(ctrl_i), .enable_i(enable_i), .pwm_o(pwm_o), .phase_o(phase_o),
    .cnt_o(cnt_o), .period_start_o(period_start_o), .update_pending_o(update_pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Waveform level for every channel at the model's current counter value
  function automatic logic [N-1:0] ideal_vec();
    logic [N-1:0] v;
    int ph, a, pos, lo;
    v = '0;
    for (int i = 0; i < N; i++) begin
      ph  = (m_ph[i] >= m_per) ? 0 : m_ph[i];
      a   = (m_act[i] > m_per) ? m_per : m_act[i];
      pos = (m_cnt - ph + m_per) % m_per;
      if (m_cen[i]) begin
        lo   = (m_per - a) / 2;
        v[i] = (pos >= lo) && (pos < lo + a);
      end else begin
        v[i] = pos < a;
      end
    end
    return v;
  endfunction

  task automatic model_edge();
    bit run, wrap, load;
    logic [N-1:0] id;
    if (rst_i) begin
      m_cnt = 0; m_per = 0; m_pend = 0; m_pstart = 0; m_pwm = '0; m_ideal = '0;
      for (int i = 0; i < N; i++) begin
        m_act[i] = 0; m_ph[i] = 0; m_lat[i] = 0; m_cen[i] = 0;
      end
      return;
    end
    run  = cnt_enable_i && (m_per != 0);
    wrap = run && (m_cnt == m_per - 1);
    id   = run ? ideal_vec() : '0;
    load = (wrap && (m_pend || update_i)) || (!run && m_pend);
    m_pwm    = m_ideal & enable_i;
    m_ideal  = id;
    m_pstart = wrap;
    m_cnt    = (!run || wrap) ? 0 : m_cnt + 1;
    if (load) begin
      m_per = int'(period_i);
      for (int i = 0; i < N; i++) begin
        m_act[i] = int'(active_i[i*W +: W]);
        m_cen[i] = center_i[i];
        m_ph[i]  = ctrl_i[i] ? m_lat[i] : int'(man_phase_i[i*W +: W]);
      end
    end
    m_pend = load ? 1'b0 : (m_pend | update_i);
    for (int i = 0; i < N; i++) begin
      if (auto_end_i[i]) m_lat[i] = int'(auto_phase_i[i*W +: W]);
    end
  endtask

  task automatic step();
    logic [N*W-1:0] exp_ph;
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) exp_ph[i*W +: W] = m_ph[i][W-1:0];
    check_eq("cnt", 64'(cnt_o), 64'(m_cnt));
    check_eq("period_start", 64'(period_start_o), 64'(m_pstart));
    check_eq("pending", 64'(update_pending_o), 64'(m_pend));
    check_eq("pwm", 64'(pwm_o), 64'(m_pwm));
    check_eq("phase", 64'(phase_o), 64'(exp_ph));
    update_i   = 1'b0;
    auto_end_i = '0;
  endtask

  task automatic run_steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Steps until the model counter reaches the target; an expired bound counts as a failure
  task automatic wait_cnt(input int target);
    int k;
    k = 0;
    while (m_cnt != target && k < 100) begin
      step();
      k++;
    end
    check_eq("wait_cnt_timeout", 64'(m_cnt), 64'(target));
  endtask

  initial begin
    int hi;
    rst_i = 1'b1; cnt_enable_i = 1'b0; period_i = '0; update_i = 1'b0;
    active_i = '0; center_i = '0; man_phase_i = '0; auto_phase_i = '0;
    auto_end_i = '0; ctrl_i = '0; enable_i = '0;
    run_steps(3);
    rst_i = 1'b0;
    run_steps(2);

    // Edge P=10: ch0 a=3 ph=0, ch1 ph=4, ch2 ph=12 (wraps to 0), ch3 centre a=4
    cnt_enable_i = 1'b1; period_i = 8'd10; enable_i = '1;
    active_i = {8'd4, 8'd3, 8'd3, 8'd3};
    man_phase_i = {8'd0, 8'd12, 8'd4, 8'd0};
    center_i = 4'b1000;
    update_i = 1'b1;
    run_steps(20);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      hi += int'(pwm_o[0]);
    end
    check_eq("duty_count_ch0", 64'(hi), 64'd6);

    // Centre a=0 then a=15 on ch3
    active_i[3*W +: W] = 8'd0; update_i = 1'b1; run_steps(25);
    active_i[3*W +: W] = 8'd15; update_i = 1'b1; run_steps(25);

    // Period change mid-period, then update exactly on the wrap cycle
    wait_cnt(5);
    period_i = 8'd20; update_i = 1'b1;
    run_steps(45);
    wait_cnt(19);
    period_i = 8'd10; update_i = 1'b1;
    run_steps(25);

    // Auto phase on ch1, then auto_end coincident with the load
    ctrl_i[1] = 1'b1;
    auto_phase_i[W +: W] = 8'd7; auto_end_i[1] = 1'b1;
    step();
    update_i = 1'b1;
    run_steps(25);
    check_eq("auto_phase_applied", 64'(phase_o[W +: W]), 64'd7);
    wait_cnt(9);
    auto_phase_i[W +: W] = 8'd2; auto_end_i[1] = 1'b1; update_i = 1'b1;
    step();
    check_eq("auto_old_on_load", 64'(phase_o[W +: W]), 64'd7);
    update_i = 1'b1;
    run_steps(25);
    check_eq("auto_new_next_load", 64'(phase_o[W +: W]), 64'd2);

    // Reset mid-period, restart, drop the counter enable, then period 0
    wait_cnt(4);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    update_i = 1'b1; run_steps(15);
    cnt_enable_i = 1'b0; run_steps(2);
    check_eq("pwm_off_after_stop", 64'(pwm_o), 64'd0);
    run_steps(4);
    cnt_enable_i = 1'b1; run_steps(12);
    period_i = 8'd0; update_i = 1'b1;
    run_steps(20);
    check_eq("period0_cnt", 64'(cnt_o), 64'd0);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      rst_i = ($urandom_range(0, 299) == 0);
      cnt_enable_i = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 7) == 0) begin
        update_i = 1'b1;
        period_i = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
        for (int i = 0; i < N; i++) begin
          active_i[i*W +: W]    = 8'($urandom_range(0, 30));
          man_phase_i[i*W +: W] = 8'($urandom_range(0, 30));
        end
        center_i = 4'($urandom_range(0, 15));
        ctrl_i   = 4'($urandom_range(0, 15));
      end
      auto_end_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      for (int i = 0; i < N; i++) auto_phase_i[i*W +: W] = 8'($urandom_range(0, 30));
      enable_i = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
